// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// ----------------
// Instruction fetch stage of the RV32I core. It owns the fetch PC and issues
// word-aligned requests to instruction memory over a valid/ready channel. It
// buffers the returned words in a small in-order queue whose head feeds the
// decode stage. Redirects from branch/jump resolution flush the queue and
// restart fetch at the target. Responses that were already in flight when a
// redirect happened are counted as stale and discarded when they arrive.
//
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   imem_req_valid/ready/addr   fetch request channel (addr word aligned)
//   imem_rsp_valid/data         in-order response words, no backpressure
//   redirect_valid/pc           taken branch / jump target
//   instr_valid/ready           head-of-queue handshake to decode
//   instr, instr_pc, instr_pc_plus4   head word, its PC and PC + 4
//   fetch_err                   sticky flag for a misaligned redirect
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          QUEUE_DEPTH     = 2,
    parameter int          MAX_OUTSTANDING = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4,
    output logic        fetch_err
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int SUM_W = 8;

    logic [31:0]      fetch_pc;
    logic [31:0]      q_word [QUEUE_DEPTH];
    logic [31:0]      q_pc   [QUEUE_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [OUT_W-1:0] outstanding;
    logic [OUT_W-1:0] drop_cnt;
    logic [OUT_W-1:0] live;
    logic             err_q;

    logic [SUM_W-1:0] credit_used;
    logic             accept;
    logic             pop;
    logic             push;
    logic             drop_rsp;
    logic             misaligned;
    logic [31:0]      rsp_pc;

    // A queue slot is reserved for every live request, so the queue can
    // never overflow even when responses arrive while decode stalls.
    assign live        = outstanding - drop_cnt;
    assign credit_used = SUM_W'(count) + SUM_W'(live);

    assign imem_req_valid = reset_n & ~err_q & ~redirect_valid
                          & (outstanding < OUT_W'(MAX_OUTSTANDING))
                          & (credit_used < SUM_W'(QUEUE_DEPTH));
    assign imem_req_addr  = fetch_pc;

    assign accept     = imem_req_valid & imem_req_ready;
    assign pop        = instr_valid & instr_ready;
    assign drop_rsp   = imem_rsp_valid & (drop_cnt != '0);
    assign push       = imem_rsp_valid & (drop_cnt == '0) & ~err_q & ~redirect_valid;
    assign misaligned = redirect_pc[1:0] != 2'b00;

    // Live requests are always consecutive words ending just below fetch_pc,
    // so the PC of the oldest one is recovered without a tag FIFO.
    assign rsp_pc = fetch_pc - (32'(live) << 2);

    assign instr_valid    = (count != '0) & ~err_q;
    assign instr          = q_word[rd_ptr];
    assign instr_pc       = q_pc[rd_ptr];
    assign instr_pc_plus4 = q_pc[rd_ptr] + 32'd4;
    assign fetch_err      = err_q;

    // Control state: fetch PC, queue pointers, request accounting and the
    // sticky error. A redirect wins over everything else in its cycle; the
    // response arriving alongside it retires one outstanding request and
    // every other in-flight request becomes stale.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fetch_pc    <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            err_q       <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc    <= {redirect_pc[31:2], 2'b00};
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= outstanding - OUT_W'(imem_rsp_valid);
            drop_cnt    <= outstanding - OUT_W'(imem_rsp_valid);
            if (misaligned) begin
                err_q <= 1'b1;
            end
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (drop_rsp) begin
                drop_cnt <= drop_cnt - OUT_W'(1);
            end
            count       <= count + CNT_W'(push) - CNT_W'(pop);
            outstanding <= outstanding + OUT_W'(accept) - OUT_W'(imem_rsp_valid);
        end
    end

    // Queue storage needs no reset; entries are only read while counted.
    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            q_word[wr_ptr] <= imem_rsp_data;
            q_pc[wr_ptr]   <= rsp_pc;
        end
    end

endmodule
